// File: rtl/ser_shift_pkg.sv
// Shared definitions for the serial shift controller: state encoding and
// the helper that sizes the bit counter from the frame length.
package ser_shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Smallest r such that 2**r >= n; used to size the bit counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register. A load takes priority over a
// shift; the outgoing bit is always the register end selected by LSB_FIRST.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift_en,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;

    // Shift direction and output tap chosen at elaboration time.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign o_bit     = r_shreg[0];
        end else begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign o_bit     = r_shreg[WIDTH-1];
        end
    endgenerate

    // Shift register storage: load wins over shift, reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift_en) begin
            r_shreg <= w_shifted;
        end
    end

endmodule

// File: rtl/ser_shift_ctrl.sv
// Serialiser controller: accepts parallel words through a valid/ready
// handshake, keeps one word pending behind the active frame, and streams
// frames back-to-back with a stall (hold) input and a frame-done pulse.
module ser_shift_ctrl
    import ser_shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] r_pend_data;
    logic [WIDTH-1:0] w_pend_data_next;
    logic             r_pend_valid;
    logic             w_pend_valid_next;
    logic             r_done;
    logic             w_done_next;

    logic             w_accept;
    logic             w_last;
    logic             w_sh_load;
    logic [WIDTH-1:0] w_sh_data;
    logic             w_sh_en;
    logic             w_bit;

    assign w_accept = load_valid && !r_pend_valid;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    piso_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_sh_load),
        .i_data     (w_sh_data),
        .i_shift_en (w_sh_en),
        .o_bit      (w_bit)
    );

    // State, counter, pending buffer and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_pend_data  <= w_pend_data_next;
            r_pend_valid <= w_pend_valid_next;
            r_done       <= w_done_next;
        end
    end

    // Next-state logic: accept, advance, end frames and chain pending words.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_pend_data_next  = r_pend_data;
        w_pend_valid_next = r_pend_valid;
        w_done_next       = 1'b0;
        w_sh_load         = 1'b0;
        w_sh_data         = load_data;
        w_sh_en           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sh_load    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold && w_last) begin
                    // Last bit consumed: chain the next word or go idle.
                    w_done_next = 1'b1;
                    w_cnt_next  = '0;
                    if (r_pend_valid) begin
                        w_sh_load         = 1'b1;
                        w_sh_data         = r_pend_data;
                        w_pend_valid_next = 1'b0;
                    end else if (w_accept) begin
                        w_sh_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    if (w_accept) begin
                        w_pend_data_next  = load_data;
                        w_pend_valid_next = 1'b1;
                    end
                    if (!hold) begin
                        w_sh_en    = 1'b1;
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy       = (r_state == ST_SHIFT);
    assign sout_en    = busy && !hold;
    assign sout       = busy && w_bit;
    assign load_ready = !r_pend_valid;
    assign done       = r_done;

endmodule
